// File: rtl/nios2_debug_pkg.sv
// Shared types and jdo field positions for the Nios II debug-module OCI RAM path.
package nios2_debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AV_RD = 2'd1,
    JT_RD = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    RD       = 2'd1,
    RD_NOINC = 2'd2,
    WR       = 2'd3
  } jop_e;

  typedef enum logic {
    GNT_AV = 1'b0,
    GNT_JT = 1'b1
  } grant_e;

  localparam int         JDO_WDATA_LSB = 3;
  localparam int         JDO_ADDR_LSB  = 17;
  localparam logic [3:0] BE_ALL        = 4'hF;

endpackage

// File: rtl/nios2_ocimem_arbiter_if.sv
// Avalon debug-slave bus as seen by the OCI RAM arbiter.
interface nios2_ocimem_arbiter_if #(
  parameter int RAM_AW = 8,
  parameter int DW     = 32
);
  logic [RAM_AW-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DW-1:0]     av_writedata;
  logic [3:0]        av_byteenable;
  logic              av_debugaccess;
  logic [DW-1:0]     av_readdata;
  logic              av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable, av_debugaccess,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/nios2_ocimem_jtag_slot.sv
// One-deep latch for the JTAG OCI RAM command strobes, plus the sticky overrun
// flag raised when a strobe finds the slot occupied or a JTAG read in flight.
module nios2_ocimem_jtag_slot
  import nios2_debug_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          take_action_ocimem_a_i,
  input  logic          take_no_action_ocimem_a_i,
  input  logic          take_action_ocimem_b_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          in_flight_i,
  input  logic          clear_i,
  output jop_e          op_o,
  output logic [DW-1:0] data_o,
  output logic          load_addr_o,
  output logic          overrun_o
);

  jop_e          op_q, op_d;
  logic [DW-1:0] data_q, data_d;
  logic          overrun_q, overrun_d;
  logic          strobe_s;
  logic          accept_s;

  assign strobe_s = take_action_ocimem_a_i | take_no_action_ocimem_a_i | take_action_ocimem_b_i;
  assign accept_s = strobe_s && (op_q == NONE) && !in_flight_i;

  // Slot contents and overrun flag next-state
  always_comb begin
    op_d        = op_q;
    data_d      = data_q;
    overrun_d   = overrun_q;
    load_addr_o = 1'b0;
    if (clear_i) begin
      op_d = NONE;
    end else begin
      op_d = op_q;
    end
    if (accept_s) begin
      if (take_action_ocimem_a_i) begin
        op_d        = RD_NOINC;
        load_addr_o = 1'b1;
      end else if (take_no_action_ocimem_a_i) begin
        op_d = RD;
      end else begin
        op_d   = WR;
        data_d = wdata_i;
      end
    end else if (strobe_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Slot state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= NONE;
      data_q    <= {DW{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign op_o      = op_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the Avalon debug slave and the JTAG
// command strobes; owns MonAReg auto-increment and MonDReg read capture.
module nios2_ocimem_arbiter
  import nios2_debug_pkg::*;
#(
  parameter int RAM_AW = 8,
  parameter int DW     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios2_ocimem_arbiter_if.slave av,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [3:0]            ram_be,
  output logic [DW-1:0]         ram_wdata,
  input  logic [DW-1:0]         ram_rdata,
  output logic [DW-1:0]         MonDReg,
  output logic [RAM_AW-1:0]     MonAReg,
  output logic                  jtag_busy,
  output logic                  jtag_overrun
);

  localparam logic [RAM_AW-1:0] ADDR_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [RAM_AW-1:0] mon_a_q, mon_a_d;
  logic [DW-1:0]     mon_d_q, mon_d_d;

  jop_e              slot_op_s;
  logic [DW-1:0]     slot_data_s;
  logic              slot_load_s;
  logic              slot_clear_s;
  logic              av_req_s;
  logic              jt_req_s;
  logic              grant_av_s;
  logic              grant_jt_s;
  logic              unused_jdo_s;

  assign unused_jdo_s = ^{jdo[JDO_WDATA_LSB-1:0], jdo[37:JDO_WDATA_LSB+DW]};

  nios2_ocimem_jtag_slot #(.DW(DW)) u_slot (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .take_action_ocimem_a_i    (take_action_ocimem_a),
    .take_no_action_ocimem_a_i (take_no_action_ocimem_a),
    .take_action_ocimem_b_i    (take_action_ocimem_b),
    .wdata_i                   (jdo[JDO_WDATA_LSB +: DW]),
    .in_flight_i               (state_q == JT_RD),
    .clear_i                   (slot_clear_s),
    .op_o                      (slot_op_s),
    .data_o                    (slot_data_s),
    .load_addr_o               (slot_load_s),
    .overrun_o                 (jtag_overrun)
  );

  // A strobe landing this cycle is not yet in the slot, so Avalon wins that cycle
  assign av_req_s = av.av_read | av.av_write;
  assign jt_req_s = (slot_op_s != NONE);

  // Grant, RAM strobes, Avalon handshake and next-state
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    mon_a_d          = slot_load_s ? jdo[JDO_ADDR_LSB +: RAM_AW] : mon_a_q;
    mon_d_d          = mon_d_q;
    slot_clear_s     = 1'b0;
    grant_av_s       = 1'b0;
    grant_jt_s       = 1'b0;
    ram_addr         = {RAM_AW{1'b0}};
    ram_rd           = 1'b0;
    ram_wr           = 1'b0;
    ram_be           = 4'h0;
    ram_wdata        = {DW{1'b0}};
    av.av_readdata   = {DW{1'b0}};
    av.av_waitrequest = 1'b0;
    case (state_q)
      IDLE: begin
        grant_av_s = av_req_s && !(jt_req_s && (last_grant_q == GNT_AV));
        grant_jt_s = jt_req_s && !grant_av_s;
        if (grant_av_s) begin
          last_grant_d = GNT_AV;
          ram_addr     = av.av_address;
          if (av.av_write) begin
            if (av.av_debugaccess) begin
              ram_wr    = 1'b1;
              ram_be    = av.av_byteenable;
              ram_wdata = av.av_writedata;
            end else begin
              ram_wr = 1'b0;
            end
            av.av_waitrequest = 1'b0;
          end else begin
            ram_rd            = 1'b1;
            av.av_waitrequest = 1'b1;
            state_d           = AV_RD;
          end
        end else if (grant_jt_s) begin
          last_grant_d      = GNT_JT;
          ram_addr          = mon_a_q;
          av.av_waitrequest = av_req_s;
          if (slot_op_s == WR) begin
            ram_wr       = 1'b1;
            ram_be       = BE_ALL;
            ram_wdata    = slot_data_s;
            mon_a_d      = mon_a_q + ADDR_ONE;
            slot_clear_s = 1'b1;
          end else begin
            ram_rd  = 1'b1;
            state_d = JT_RD;
          end
        end else begin
          av.av_waitrequest = 1'b0;
        end
      end
      AV_RD: begin
        av.av_readdata    = ram_rdata;
        av.av_waitrequest = 1'b0;
        state_d           = IDLE;
      end
      JT_RD: begin
        mon_d_d           = ram_rdata;
        slot_clear_s      = 1'b1;
        av.av_waitrequest = av_req_s;
        state_d           = IDLE;
        if (slot_op_s != RD_NOINC) begin
          mon_a_d = mon_a_q + ADDR_ONE;
        end else begin
          mon_a_d = mon_a_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state, grant history and JTAG monitor registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_AV;
      mon_a_q      <= {RAM_AW{1'b0}};
      mon_d_q      <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mon_a_q      <= mon_a_d;
      mon_d_q      <= mon_d_d;
    end
  end

  assign MonAReg   = mon_a_q;
  assign MonDReg   = mon_d_q;
  assign jtag_busy = jt_req_s || (state_q == JT_RD);

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug monitor RAM (OCI RAM) between two requesters: the CPU's Avalon debug-slave port and the JTAG debug path's sysclk-domain command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a, with jdo).
- Sequences the RAM accesses, owns the JTAG address auto-increment register (MonAReg), and captures JTAG read data into MonDReg for the TCK-side shift chain.
- Sits in the CPU's debug module, between the debug slave wrapper outputs and the OCI RAM macro.

Parameters:
- RAM_AW, 8, OCI RAM word-address width.
- DW, 32, RAM data width (fixed at 32; jdo slicing depends on it).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- av_address  in  RAM_AW  Avalon word address
- av_read  in  1  Avalon read request
- av_write  in  1  Avalon write request
- av_writedata  in  32  Avalon write data
- av_byteenable  in  4  Avalon byte enables
- av_debugaccess  in  1  write permitted only when 1
- av_readdata  out  32  Avalon read data
- av_waitrequest  out  1  Avalon stall
- jdo  in  38  JTAG data: address in jdo[RAM_AW+16:17], write data in jdo[34:3]
- take_action_ocimem_a  in  1  load MonAReg, then read
- take_no_action_ocimem_a  in  1  read at MonAReg, then increment
- take_action_ocimem_b  in  1  write at MonAReg, then increment
- ram_addr  out  RAM_AW  RAM address
- ram_rd  out  1  RAM read strobe
- ram_wr  out  1  RAM write strobe
- ram_be  out  4  RAM byte enables
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_rd
- MonDReg  out  32  last JTAG read data
- MonAReg  out  RAM_AW  JTAG address pointer
- jtag_busy  out  1  JTAG command pending or in flight
- jtag_overrun  out  1  sticky: a JTAG strobe was dropped

Behaviour:
- Reset: all outputs are 0. This covers av_waitrequest, MonDReg, MonAReg, jtag_overrun, and the RAM strobes. FSM goes to IDLE, the pending slot is cleared, and last_grant is set to AV. Assertion mid-operation abandons any in-flight access; no RAM strobe follows.
- JTAG strobes (single-cycle pulses):
  - Each strobe is latched into a one-deep pending slot (op RD/WR, data).
  - take_action_ocimem_a sets MonAReg <= jdo[RAM_AW+16:17] in the strobe cycle and queues RD.
  - A strobe arriving while the slot is full or a JTAG op is in flight is dropped and sets jtag_overrun. The flag clears only on reset.
- FSM states: IDLE, AV_RD, JT_RD.
  - IDLE grant rule:
    - If only one requester is present, grant it.
    - If both are present, grant the one not equal to last_grant; last_grant updates on each grant.
    - A JTAG strobe arriving in the same cycle as an Avalon request, with the slot empty, counts as not yet pending: Avalon is granted.
  - Avalon write granted:
    - If av_debugaccess=1: ram_wr=1 and ram_be=av_byteenable.
    - If av_debugaccess=0: no strobe; the write completes silently.
    - av_waitrequest=0 that cycle; stay in IDLE.
  - Avalon read granted: ram_rd=1, av_waitrequest=1, go to AV_RD.
  - AV_RD: av_readdata=ram_rdata (combinational), av_waitrequest=0, go to IDLE. Read latency is 2 cycles.
  - JTAG WR granted: ram_wr=1, ram_be=4'hF, ram_wdata=pending data, MonAReg+1, slot cleared, stay in IDLE.
  - JTAG RD granted: ram_rd=1 at MonAReg, go to JT_RD.
  - JT_RD: MonDReg <= ram_rdata; MonAReg+1 unless the op came from take_action_ocimem_a; slot cleared; go to IDLE.
- Avalon stall: av_waitrequest=1 whenever (av_read|av_write) is present and not completing this cycle. The Avalon master must hold its request stable.
- MonAReg arithmetic: modulo 2^RAM_AW; all-ones wraps to 0.
- jtag_busy = slot full OR state==JT_RD.
- ram_addr = granted requester's address; 0 when idle.

Decomposition:
- Shared package nios2_debug_pkg holds:
  - the state enum {IDLE, AV_RD, JT_RD};
  - the pending-op enum {NONE, RD, RD_NOINC, WR};
  - jdo field constants JDO_WDATA_LSB=3 and JDO_ADDR_LSB=17.
- One natural sub-module: nios2_ocimem_jtag_slot, the pending-command latch plus overrun flag.

Test Plan:
- Reset mid-JT_RD: reset asserted in the cycle after ram_rd -> MonDReg=0, MonAReg=0, no further RAM strobe, jtag_busy=0.
- Avalon write with debugaccess=1: addr 0x10, data 0xDEADBEEF, be 4'hF -> same-cycle ram_wr, waitrequest=0. Then read of addr 0x10 -> waitrequest 1,0; readdata=0xDEADBEEF on the 2nd cycle.
- Avalon write with debugaccess=0: addr 0x10, data 0x12345678 -> no ram_wr; a subsequent read still returns 0xDEADBEEF.
- JTAG load and read: take_action_ocimem_a with address field 0x10 -> MonAReg=0x10, MonDReg=0xDEADBEEF two cycles later, MonAReg stays 0x10. Then take_no_action_ocimem_a -> MonAReg=0x11.
- Contention: JTAG WR pending while a continuous Avalon read stream runs, last_grant=AV -> JTAG granted first, Avalon stalled 1 cycle. Next contention goes to Avalon.
- Wrap and overrun: MonAReg=0xFF, take_action_ocimem_b -> write at 0xFF, MonAReg=0x00. A second strobe the cycle after a strobe that is still pending -> jtag_overrun=1, dropped command causes no RAM access.
